exec_ctrl: RTL and testbench

//  Instruction fetch/decode/sequence controller for one SincereMicro core.
//  - Reads program memory and decodes each word.
//  - Drives inst/arg1/arg2/acc into the alu block and writes alu results back into acc.
//  - Owns pc, acc, dat, the +/- test flags and the sleep timer.
//  - Only producer of alu operands and only consumer of alu results.

---
 rtl/sincere_pkg.sv | 47 ++++
 rtl/tst_unit.sv | 34 +++
 rtl/exec_ctrl.sv | 154 +++++++++++++++
 tb/tb_exec_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sincere_pkg.sv
// sincere_pkg: shared constants for the SincereMicro execution controller.
//  - opcode values, instruction field bit positions, condition codes
//  - value range of the 11-bit data path (+/-999)
//  - FSM state encodings for exec_ctrl
package sincere_pkg;

    localparam int VAL_W   = 11;
    localparam int VAL_MAX = 999;
    localparam int VAL_MIN = -999;

    // Opcodes (5..10 are handled by the external alu)
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_JMP  = 4'd2;
    localparam logic [3:0] OP_SLP  = 4'd3;
    localparam logic [3:0] OP_TEQ  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_DST  = 4'd10;
    localparam logic [3:0] OP_TGT  = 4'd11;
    localparam logic [3:0] OP_TLT  = 4'd12;
    localparam logic [3:0] OP_TCP  = 4'd13;
    localparam logic [3:0] OP_MVD  = 4'd14;
    localparam logic [3:0] OP_NOP2 = 4'd15;

    // Instruction field positions
    localparam int F_SEL     = 28;
    localparam int F_COND_HI = 27;
    localparam int F_COND_LO = 26;
    localparam int F_OP_HI   = 25;
    localparam int F_OP_LO   = 22;
    localparam int F_A1_HI   = 21;
    localparam int F_A1_LO   = 11;
    localparam int F_A2_HI   = 10;
    localparam int F_A2_LO   = 0;

    // Condition codes
    localparam logic [1:0] COND_ALWAYS  = 2'b00;
    localparam logic [1:0] COND_PLUS    = 2'b01;
    localparam logic [1:0] COND_MINUS   = 2'b10;
    localparam logic [1:0] COND_ALWAYS2 = 2'b11;

    // FSM states
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] SLEEP = 2'd2;

endpackage

// File: rtl/tst_unit.sv
// tst_unit: combinational evaluation of the test opcodes.
//  opcode     in  4   instruction opcode
//  a, b       in  11  signed operands (arg1, arg2)
//  is_test    out 1   opcode is one of TEQ/TGT/TLT/TCP
//  flags_next out 2   {plus, minus} value to load when the test executes
module tst_unit
    import sincere_pkg::*;
(
    input  logic [3:0]       opcode,
    input  logic [VAL_W-1:0] a,
    input  logic [VAL_W-1:0] b,
    output logic             is_test,
    output logic [1:0]       flags_next
);

    logic a_gt_b;
    logic a_lt_b;

    assign a_gt_b = $signed(a) > $signed(b);
    assign a_lt_b = $signed(a) < $signed(b);

    always_comb begin
        is_test    = 1'b1;
        flags_next = 2'b00;
        case (opcode)
            OP_TEQ:  flags_next = (a == b) ? 2'b10 : 2'b01;
            OP_TGT:  flags_next = a_gt_b ? 2'b10 : 2'b01;
            OP_TLT:  flags_next = a_lt_b ? 2'b10 : 2'b01;
            OP_TCP:  flags_next = a_gt_b ? 2'b10 : (a_lt_b ? 2'b01 : 2'b00);
            default: is_test = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: fetch/decode/sequence controller for one SincereMicro core.
//  clk, rst           clock (rising edge), asynchronous active-high reset
//  en                 run enable, sampled only in FETCH
//  imem_addr/rd/data  program memory port (sync read, 1-cycle latency)
//  alu_inst/arg1/arg2/acc -> alu, alu_out <- alu (combinational)
//  acc, dat           accumulator and data register
//  plus_flag/minus_flag  condition flags from the last executed test op
//  sleeping           high while in SLEEP
// Each instruction takes FETCH + EXEC (2 cycles); SLP n adds n SLEEP cycles.
module exec_ctrl
    import sincere_pkg::*;
#(
    parameter int PC_W     = 4,
    parameter int PROG_LEN = 14,
    parameter int INST_W   = 29
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_rd,
    input  logic [INST_W-1:0] imem_data,
    output logic [3:0]        alu_inst,
    output logic [10:0]       alu_arg1,
    output logic [10:0]       alu_arg2,
    output logic [10:0]       alu_acc,
    input  logic [10:0]       alu_out,
    output logic [10:0]       acc,
    output logic [10:0]       dat,
    output logic              plus_flag,
    output logic              minus_flag,
    output logic              sleeping
);

    logic [1:0]       state_reg;
    logic [PC_W-1:0]  pc_reg;
    logic [10:0]      acc_reg;
    logic [10:0]      dat_reg;
    logic             plus_reg;
    logic             minus_reg;
    logic [9:0]       cnt_reg;

    // Decode of the word returned for the fetch issued in the previous cycle
    logic             arg1_sel;
    logic [1:0]       cond;
    logic [3:0]       opcode;
    logic [10:0]      imm1;
    logic [10:0]      imm2;
    logic [10:0]      arg1;
    logic             cond_ok;
    logic             is_alu;
    logic             is_test;
    logic [1:0]       flags_next;
    logic [PC_W-1:0]  pc_next;
    logic [PC_W-1:0]  jmp_target;
    logic             slp_go;
    logic [9:0]       slp_n;

    assign arg1_sel = imem_data[F_SEL];
    assign cond     = imem_data[F_COND_HI:F_COND_LO];
    assign opcode   = imem_data[F_OP_HI:F_OP_LO];
    assign imm1     = imem_data[F_A1_HI:F_A1_LO];
    assign imm2     = imem_data[F_A2_HI:F_A2_LO];
    assign arg1     = arg1_sel ? dat_reg : imm1;

    always_comb begin
        case (cond)
            COND_PLUS:  cond_ok = plus_reg;
            COND_MINUS: cond_ok = minus_reg;
            default:    cond_ok = 1'b1;
        endcase
    end

    assign is_alu = (opcode >= OP_ADD) && (opcode <= OP_DST);

    tst_unit u_tst (
        .opcode     (opcode),
        .a          (arg1),
        .b          (imm2),
        .is_test    (is_test),
        .flags_next (flags_next)
    );

    assign pc_next = (pc_reg == PC_W'(PROG_LEN - 1)) ? '0 : pc_reg + PC_W'(1);

    // Out-of-range jump targets (negative or past the last line) restart at 0
    assign jmp_target = (!arg1[10] && (arg1 < 11'(PROG_LEN))) ? arg1[PC_W-1:0] : '0;

    // Non-positive sleep lengths act as NOP; long ones saturate at VAL_MAX
    assign slp_go = !arg1[10] && (arg1 != 11'd0);
    assign slp_n  = (arg1 > 11'(VAL_MAX)) ? 10'(VAL_MAX) : arg1[9:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FETCH;
            pc_reg    <= '0;
            acc_reg   <= '0;
            dat_reg   <= '0;
            plus_reg  <= 1'b0;
            minus_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (en) state_reg <= EXEC;
                end
                EXEC: begin
                    state_reg <= FETCH;
                    pc_reg    <= pc_next;
                    // A skipped line only advances pc
                    if (cond_ok) begin
                        if (is_test) begin
                            {plus_reg, minus_reg} <= flags_next;
                        end else if (is_alu) begin
                            acc_reg <= alu_out;
                        end else begin
                            case (opcode)
                                OP_MOV: acc_reg <= arg1;
                                OP_JMP: pc_reg  <= jmp_target;
                                OP_SLP: begin
                                    if (slp_go) begin
                                        state_reg <= SLEEP;
                                        cnt_reg   <= slp_n;
                                    end
                                end
                                OP_MVD: dat_reg <= arg1;
                                default: ;
                            endcase
                        end
                    end
                end
                SLEEP: begin
                    if (cnt_reg == 10'd1) state_reg <= FETCH;
                    else                  cnt_reg   <= cnt_reg - 10'd1;
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

    assign imem_addr  = pc_reg;
    assign imem_rd    = !rst && en && (state_reg == FETCH);
    // The alu is only told about operations that will actually commit
    assign alu_inst   = ((state_reg == EXEC) && cond_ok && is_alu) ? opcode : 4'd0;
    assign alu_arg1   = arg1;
    assign alu_arg2   = imm2;
    assign alu_acc    = acc_reg;
    assign acc        = acc_reg;
    assign dat        = dat_reg;
    assign plus_flag  = plus_reg;
    assign minus_flag = minus_reg;
    assign sleeping   = (state_reg == SLEEP);

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: scoreboard bench for exec_ctrl.
// Stimulus loads a program and pushes one expected snapshot per fetch; a
// monitor compares each fetch (imem_rd) against the next snapshot.
module tb_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [3:0]  imem_addr;
    logic        imem_rd;
    logic [28:0] imem_data;
    logic [3:0]  alu_inst;
    logic [10:0] alu_arg1, alu_arg2, alu_acc, alu_out, acc, dat;
    logic        plus_flag, minus_flag, sleeping;

    // Second instance with a 3-line program to observe natural pc wrap
    logic [3:0]  addr3;
    logic        rd3;
    logic [28:0] data3;
    logic [3:0]  inst3;
    logic [10:0] a1_3, a2_3, acc_in3, aout3, acc3, dat3;
    logic        plus3, minus3, slp3;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int addr; int cyc; int acc; int dat; int flags; int alu; int slp;
    } rec_t;

    rec_t q[$];
    int   q3[$];
    logic [28:0] prog [0:15];

    always #5 clk = ~clk;

    exec_ctrl #(.PC_W(4), .PROG_LEN(14), .INST_W(29)) dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
        .alu_inst(alu_inst), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2),
        .alu_acc(alu_acc), .alu_out(alu_out),
        .acc(acc), .dat(dat), .plus_flag(plus_flag), .minus_flag(minus_flag),
        .sleeping(sleeping)
    );

    exec_ctrl #(.PC_W(4), .PROG_LEN(3), .INST_W(29)) dut3 (
        .clk(clk), .rst(rst), .en(en),
        .imem_addr(addr3), .imem_rd(rd3), .imem_data(data3),
        .alu_inst(inst3), .alu_arg1(a1_3), .alu_arg2(a2_3),
        .alu_acc(acc_in3), .alu_out(aout3),
        .acc(acc3), .dat(dat3), .plus_flag(plus3), .minus_flag(minus3),
        .sleeping(slp3)
    );

    assign data3 = '0;   // all NOP
    assign aout3 = '0;

    // Program memory: registered read, one-cycle latency
    always @(posedge clk) if (imem_rd) imem_data <= prog[imem_addr];

    // Minimal alu: ADD/SUB with +/-999 saturation, others pass acc through
    function automatic logic [10:0] clamp(int v);
        if (v > 999)  return 11'(999);
        if (v < -999) return 11'(-999);
        return 11'(v);
    endfunction

    always_comb begin
        alu_out = alu_acc;
        case (alu_inst)
            4'd5: alu_out = clamp(int'($signed(alu_acc)) + int'($signed(alu_arg1)));
            4'd6: alu_out = clamp(int'($signed(alu_acc)) - int'($signed(alu_arg1)));
            default: ;
        endcase
    end

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [28:0] enc(int sel, int cond, int op, int a1, int a2);
        logic [10:0] x1, x2;
        logic [1:0]  c;
        logic [3:0]  o;
        x1 = a1[10:0];
        x2 = a2[10:0];
        c  = cond[1:0];
        o  = op[3:0];
        return {sel[0], c, o, x1, x2};
    endfunction

    task automatic expf(int addr, int cyc, int a, int d, int fl, int alu, int s);
        rec_t r;
        r.addr = addr; r.cyc = cyc; r.acc = a; r.dat = d;
        r.flags = fl; r.alu = alu; r.slp = s;
        q.push_back(r);
    endtask

    // Monitor: one line per compared fetch transaction
    int   ncyc, slp_cnt, alu_exp;
    logic alu_pend;
    initial begin
        ncyc = 0; slp_cnt = 0; alu_exp = 0; alu_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ncyc = 0; slp_cnt = 0; alu_pend = 1'b0;
            end else begin
                if (alu_pend) begin
                    chk("alu_inst", int'(alu_inst), alu_exp);
                    alu_pend = 1'b0;
                end
                if (sleeping) slp_cnt++;
                if (imem_rd && q.size() > 0) begin
                    rec_t r;
                    r = q.pop_front();
                    $display("fetch cyc=%0d addr=%0d acc=%0d dat=%0d flags=%0d%0d slp=%0d",
                             ncyc, imem_addr, $signed(acc), $signed(dat),
                             plus_flag, minus_flag, slp_cnt);
                    chk("fetch_addr",  int'(imem_addr), r.addr);
                    chk("fetch_cycle", ncyc, r.cyc);
                    chk("acc",         int'($signed(acc)), r.acc);
                    chk("dat",         int'($signed(dat)), r.dat);
                    chk("flags",       int'({plus_flag, minus_flag}), r.flags);
                    chk("sleep_cycles", slp_cnt, r.slp);
                    alu_exp  = r.alu;
                    alu_pend = 1'b1;
                    slp_cnt  = 0;
                end
                ncyc++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rd3 && q3.size() > 0) begin
            int e;
            e = q3.pop_front();
            $display("dut3 fetch addr=%0d", addr3);
            chk("dut3_addr", int'(addr3), e);
        end
    end

    task automatic check_reset();
        chk("rst_acc",      int'(acc), 0);
        chk("rst_dat",      int'(dat), 0);
        chk("rst_flags",    int'({plus_flag, minus_flag}), 0);
        chk("rst_sleeping", int'(sleeping), 0);
        chk("rst_imem_rd",  int'(imem_rd), 0);
        chk("rst_alu_inst", int'(alu_inst), 0);
        chk("rst_pc",       int'(imem_addr), 0);
    endtask

    task automatic begin_test();
        @(posedge clk); #1;
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 16; i++) prog[i] = '0;
    endtask

    task automatic go(int en_delay);
        repeat (2) @(posedge clk);
        #1;
        if (en_delay > 0) en = 1'b0;
        rst = 1'b0;
        if (en_delay > 0) begin
            repeat (en_delay) @(posedge clk);
            #1;
            en = 1'b1;
        end
    endtask

    task automatic drain(string nm, int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            if (q.size() == 0 && q3.size() == 0) break;
        end
        if (i >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: %0d expected fetches still pending, required 0",
                     nm, q.size() + q3.size());
            q.delete();
            q3.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state with en already high
        repeat (3) @(posedge clk);
        #1;
        check_reset();

        // 1: MOV 5; ADD 3, enable held low for 3 cycles after release
        begin_test();
        prog[0] = enc(0, 0, 1, 5, 0);
        prog[1] = enc(0, 0, 5, 3, 0);
        expf(0, 3, 0, 0, 0, 0, 0);
        expf(1, 5, 5, 0, 0, 5, 0);
        expf(2, 7, 8, 0, 0, 0, 0);
        go(3);
        drain("t1", 60);

        // 2: TEQ 4,4; +MOV 1; -MOV 2
        begin_test();
        prog[0] = enc(0, 0, 4, 4, 4);
        prog[1] = enc(0, 1, 1, 1, 0);
        prog[2] = enc(0, 2, 1, 2, 0);
        expf(0, 0, 0, 0, 0, 0, 0);
        expf(1, 2, 0, 0, 2, 0, 0);
        expf(2, 4, 1, 0, 2, 0, 0);
        expf(3, 6, 1, 0, 2, 0, 0);
        go(0);
        drain("t2", 60);

        // 3: JMP 11; JMP 20 (out of range -> 0); 3-line instance wraps 0,1,2,0
        begin_test();
        prog[0]  = enc(0, 0, 2, 11, 0);
        prog[11] = enc(0, 0, 2, 20, 0);
        expf(0, 0, 0, 0, 0, 0, 0);
        expf(11, 2, 0, 0, 0, 0, 0);
        expf(0, 4, 0, 0, 0, 0, 0);
        expf(11, 6, 0, 0, 0, 0, 0);
        q3.push_back(0); q3.push_back(1); q3.push_back(2);
        q3.push_back(0); q3.push_back(1);
        go(0);
        drain("t3", 60);

        // 4: SLP 3; SLP -2; SLP 1023 (clamped to 999); JMP -3 (-> 0)
        begin_test();
        prog[0] = enc(0, 0, 3, 3, 0);
        prog[1] = enc(0, 0, 3, -2, 0);
        prog[2] = enc(0, 0, 3, 1023, 0);
        prog[3] = enc(0, 0, 2, -3, 0);
        expf(0, 0, 0, 0, 0, 0, 0);
        expf(1, 5, 0, 0, 0, 0, 3);
        expf(2, 7, 0, 0, 0, 0, 0);
        expf(3, 1008, 0, 0, 0, 0, 999);
        expf(0, 1010, 0, 0, 0, 0, 0);
        go(0);
        drain("t4", 1200);

        // 5: TGT 9,1; TCP 7,7; +MOV 1; -MOV 2
        begin_test();
        prog[0] = enc(0, 0, 11, 9, 1);
        prog[1] = enc(0, 0, 13, 7, 7);
        prog[2] = enc(0, 1, 1, 1, 0);
        prog[3] = enc(0, 2, 1, 2, 0);
        expf(0, 0, 0, 0, 0, 0, 0);
        expf(1, 2, 0, 0, 2, 0, 0);
        expf(2, 4, 0, 0, 0, 0, 0);
        expf(3, 6, 0, 0, 0, 0, 0);
        expf(4, 8, 0, 0, 0, 0, 0);
        go(0);
        drain("t5", 60);

        // 6: dat-sourced operands: MVD -7; MOV dat; TLT dat,0; -MOV 3; +ADD 4
        begin_test();
        prog[0] = enc(0, 0, 14, -7, 0);
        prog[1] = enc(1, 0, 1, 0, 0);
        prog[2] = enc(1, 0, 12, 0, 0);
        prog[3] = enc(0, 2, 1, 3, 0);
        prog[4] = enc(0, 1, 5, 4, 0);
        expf(0, 0, 0, 0, 0, 0, 0);
        expf(1, 2, 0, -7, 0, 0, 0);
        expf(2, 4, -7, -7, 0, 0, 0);
        expf(3, 6, -7, -7, 2, 0, 0);
        expf(4, 8, -7, -7, 2, 5, 0);
        expf(5, 10, -3, -7, 2, 0, 0);
        go(0);
        drain("t6", 60);

        // 7: reset in the middle of SLP 500
        begin_test();
        prog[0] = enc(0, 0, 1, 7, 0);
        prog[1] = enc(0, 0, 14, 9, 0);
        prog[2] = enc(0, 0, 4, 1, 1);
        prog[3] = enc(0, 0, 3, 500, 0);
        expf(0, 0, 0, 0, 0, 0, 0);
        expf(1, 2, 7, 0, 0, 0, 0);
        expf(2, 4, 7, 9, 0, 0, 0);
        expf(3, 6, 7, 9, 2, 0, 0);
        go(0);
        drain("t7a", 60);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_sleep", int'(sleeping), 1);
        rst = 1'b1;
        #1;
        check_reset();
        expf(0, 0, 0, 0, 0, 0, 0);
        expf(1, 2, 7, 0, 0, 0, 0);
        go(0);
        drain("t7b", 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
